counter_cmd_dispatcher: RTL and testbench

- Upstream command stage for the counter top: queues count-value commands and launches them one at a time into the counter.
- Buffers up to DEPTH commands in an internal FIFO.
- Pulses `ctr_start_o` with the head value when the counter reports idle, then holds until the counter reports done.
- Gives the producer a valid/ready interface decoupled from counter run time.

---
 rtl/counter_cmd_dispatcher.sv | 115 +++++++++++
 tb/tb_counter_cmd_dispatcher.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_cmd_dispatcher.sv
// Command dispatcher: buffers count-value commands in a small FIFO and launches
// them one at a time into the counter, waiting for done before the next launch.
module counter_cmd_dispatcher #(
    parameter int CNT_WIDTH  = 7,
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid_i,
    input  logic [CNT_WIDTH-1:0] cmd_val_i,
    output logic                 cmd_ready_o,
    input  logic                 flush_i,
    input  logic                 ctr_idle_i,
    input  logic                 ctr_done_i,
    output logic                 ctr_start_o,
    output logic [CNT_WIDTH-1:0] ctr_cnt_val_o,
    output logic [ADDR_WIDTH:0]  fifo_level_o,
    output logic                 busy_o,
    output logic                 job_done_o,
    output logic                 zero_drop_o
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    localparam logic [ADDR_WIDTH:0] FULL_LEVEL = (ADDR_WIDTH + 1)'(DEPTH);

    state_t                state;
    state_t                state_next;
    logic [CNT_WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   level;
    logic                  accept;
    logic                  push;
    logic                  pop;

    assign cmd_ready_o  = (level != FULL_LEVEL);
    assign accept       = cmd_valid_i && cmd_ready_o;
    assign push         = accept && (cmd_val_i != '0);
    assign pop          = (state == S_IDLE) && (level != '0) && ctr_idle_i;
    assign fifo_level_o = level;

    always_ff @(posedge clk) begin
        if (push && !flush_i) begin
            mem[wr_ptr] <= cmd_val_i;
        end
    end

    // Flush wins over push/pop for the FIFO bookkeeping, but a same-cycle pop
    // still launches the head it read, since the FSM is not affected by flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + (ADDR_WIDTH + 1)'(1);
                2'b01:   level <= level - (ADDR_WIDTH + 1)'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            ctr_cnt_val_o <= '0;
            job_done_o    <= 1'b0;
            zero_drop_o   <= 1'b0;
        end else begin
            state       <= state_next;
            job_done_o  <= (state == S_WAIT) && ctr_done_i;
            zero_drop_o <= accept && (cmd_val_i == '0);
            if (pop) begin
                ctr_cnt_val_o <= mem[rd_ptr];
            end
        end
    end

    always_comb begin
        state_next  = state;
        ctr_start_o = 1'b0;
        busy_o      = 1'b0;
        case (state)
            S_IDLE: begin
                if (pop) begin
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                ctr_start_o = 1'b1;
                busy_o      = 1'b1;
                state_next  = S_WAIT;
            end
            S_WAIT: begin
                busy_o = 1'b1;
                if (ctr_done_i) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_counter_cmd_dispatcher.sv
// Self-checking bench: queue-based reference model of the dispatcher plus a
// behavioural counter that answers start pulses with a done after a set run.
module tb_counter_cmd_dispatcher;
    localparam int CW    = 7;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic [CW-1:0] cmd_val;
    logic          cmd_ready;
    logic          flush;
    logic          ctr_idle;
    logic          ctr_done;
    logic          ctr_start;
    logic [CW-1:0] ctr_cnt_val;
    logic [AW:0]   fifo_level;
    logic          busy;
    logic          job_done;
    logic          zero_drop;

    always #5 clk = ~clk;

    counter_cmd_dispatcher #(
        .CNT_WIDTH (CW),
        .DEPTH     (DEPTH),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid_i  (cmd_valid),
        .cmd_val_i    (cmd_val),
        .cmd_ready_o  (cmd_ready),
        .flush_i      (flush),
        .ctr_idle_i   (ctr_idle),
        .ctr_done_i   (ctr_done),
        .ctr_start_o  (ctr_start),
        .ctr_cnt_val_o(ctr_cnt_val),
        .fifo_level_o (fifo_level),
        .busy_o       (busy),
        .job_done_o   (job_done),
        .zero_drop_o  (zero_drop)
    );

    typedef struct {
        bit          valid;
        logic [CW-1:0] val;
        int          exp_level;
        bit          exp_ready;
        bit          exp_drop;
    } vec_t;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [CW-1:0] exp_q[$];
    logic [CW-1:0] cur_job = '0;
    bit            model_busy = 1'b0;
    bit            model_issue = 1'b0;
    bit            auto_ctr = 1'b1;
    int            run_len = 3;
    int            run_left = 0;
    int            jobs_seen = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: predict from pre-edge inputs, clock, then compare and play counter.
    task automatic step();
        bit            acc;
        bit            pop;
        bit            exp_drop;
        bit            exp_done;
        logic [CW-1:0] head;
        acc      = cmd_valid && cmd_ready;
        exp_drop = acc && (cmd_val == '0);
        exp_done = ctr_done && model_busy && !model_issue;
        pop      = !model_busy && (exp_q.size() > 0) && ctr_idle;
        if (flush) begin
            if (pop) begin
                head = exp_q[0];
                exp_q.delete();
                exp_q.push_back(head);
            end else begin
                exp_q.delete();
            end
        end else if (acc && cmd_val != '0) begin
            exp_q.push_back(cmd_val);
        end
        if (pop) model_busy = 1'b1;
        else if (exp_done) model_busy = 1'b0;
        model_issue = pop;

        @(posedge clk);
        #1;
        check("start", int'(ctr_start), int'(pop));
        check("job_done", int'(job_done), int'(exp_done));
        check("zero_drop", int'(zero_drop), int'(exp_drop));
        check("busy", int'(busy), int'(model_busy));
        if (ctr_start) begin
            if (exp_q.size() == 0) check("start_unexpected", int'(ctr_start), 0);
            else begin
                cur_job = exp_q.pop_front();
                check("start_val", int'(ctr_cnt_val), int'(cur_job));
            end
        end else if (busy) begin
            check("hold_val", int'(ctr_cnt_val), int'(cur_job));
        end
        check("level", int'(fifo_level), exp_q.size());
        check("ready", int'(cmd_ready), int'(exp_q.size() < DEPTH));
        if (job_done) jobs_seen++;
        if (auto_ctr) begin
            if (ctr_done) begin
                ctr_done = 1'b0;
                ctr_idle = 1'b1;
            end else if (ctr_start) begin
                ctr_idle = 1'b0;
                run_left = run_len;
            end else if (run_left > 0) begin
                run_left--;
                if (run_left == 0) ctr_done = 1'b1;
            end
        end
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while ((busy || exp_q.size() != 0 || !ctr_idle) && n < max) begin
            step();
            n++;
        end
        check("drain_in_budget", int'(busy || exp_q.size() != 0 || !ctr_idle), 0);
    endtask

    task automatic push_cmd(input logic [CW-1:0] v);
        int n = 0;
        bit acc = 1'b0;
        cmd_valid = 1'b1;
        cmd_val   = v;
        while (!acc && n < 100) begin
            acc = cmd_ready;
            step();
            n++;
        end
        check("push_accepted", int'(acc), 1);
        cmd_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_start"}, int'(ctr_start), 0);
        check({tag, "_cnt_val"}, int'(ctr_cnt_val), 0);
        check({tag, "_level"}, int'(fifo_level), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_job_done"}, int'(job_done), 0);
        check({tag, "_zero_drop"}, int'(zero_drop), 0);
        check({tag, "_ready"}, int'(cmd_ready), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          tbl[6];
        logic [CW-1:0] wrap_vals[7];
        int            lat;

        tbl[0] = '{1'b1, 7'd3,  1, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 7'd0,  1, 1'b1, 1'b1};
        tbl[2] = '{1'b1, 7'd7,  2, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 7'd9,  3, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 7'd2,  4, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 7'd11, 4, 1'b0, 1'b0};
        wrap_vals = '{7'd10, 7'd20, 7'd30, 7'd40, 7'd50, 7'd60, 7'd70};

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_val = '0; flush = 1'b0;
        ctr_idle = 1'b1; ctr_done = 1'b0;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Single job, start two cycles after acceptance.
        cmd_valid = 1'b1; cmd_val = 7'd5;
        step();
        cmd_valid = 1'b0;
        lat = 1;
        while (!ctr_start && lat < 10) begin
            step();
            lat++;
        end
        check("latency", lat, 2);
        wait_idle(50);
        check("jobs_after_single", jobs_seen, 1);
        check("single_level", int'(fifo_level), 0);

        // Fill while the counter is busy; fifth push must stall.
        auto_ctr = 1'b0; ctr_idle = 1'b0;
        foreach (tbl[i]) begin
            cmd_valid = tbl[i].valid;
            cmd_val   = tbl[i].val;
            step();
            check("tbl_level", int'(fifo_level), tbl[i].exp_level);
            check("tbl_ready", int'(cmd_ready), int'(tbl[i].exp_ready));
            check("tbl_drop", int'(zero_drop), int'(tbl[i].exp_drop));
        end
        cmd_valid = 1'b0;
        ctr_done = 1'b1;
        step();
        ctr_done = 1'b0;
        step();
        auto_ctr = 1'b1; ctr_idle = 1'b1; run_len = 4;
        wait_idle(200);
        check("jobs_after_fill", jobs_seen, 5);

        // Zero-value command is dropped.
        cmd_valid = 1'b1; cmd_val = 7'd0;
        step();
        cmd_valid = 1'b0;
        check("zero_pulse", int'(zero_drop), 1);
        for (int i = 0; i < 3; i++) step();
        check("zero_level", int'(fifo_level), 0);

        // Flush with a queued command and a same-cycle push during S_WAIT.
        run_len = 10;
        push_cmd(7'd6);
        push_cmd(7'd8);
        step();
        flush = 1'b1; cmd_valid = 1'b1; cmd_val = 7'd4;
        step();
        flush = 1'b0; cmd_valid = 1'b0;
        check("flush_level", int'(fifo_level), 0);
        check("flush_busy", int'(busy), 1);
        check("flush_job_val", int'(ctr_cnt_val), 6);
        wait_idle(100);
        check("jobs_after_flush", jobs_seen, 6);

        // DEPTH+3 commands streamed back to back to wrap the pointers.
        run_len = 1;
        foreach (wrap_vals[i]) push_cmd(wrap_vals[i]);
        wait_idle(200);
        check("jobs_after_wrap", jobs_seen, 13);

        // Reset while a job runs with two commands queued.
        run_len = 20;
        push_cmd(7'd11);
        push_cmd(7'd12);
        push_cmd(7'd13);
        step();
        check("pre_reset_level", int'(fifo_level), 2);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        exp_q.delete();
        model_busy = 1'b0; model_issue = 1'b0; cur_job = '0;
        run_left = 0; ctr_done = 1'b0; ctr_idle = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check("post_reset_no_start", int'(busy), 0);
        push_cmd(7'd15);
        wait_idle(100);
        check("jobs_after_reset", jobs_seen, 14);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
